apb_uart_core: RTL
==================

# apb_uart_core

- Parametrised APB3 slave UART, 8N1 framing.
- Register map; TX and RX FIFOs of configurable depth; programmable 16x-oversampling baud generator; maskable interrupt; APB error signalling.
- Successor to the fixed APB UART master core. Sits behind the APB bus under the same DRV/MON verification environment; TXD/RXD go to the pads or to a loopback in the bench.

## Interface
Parameters:
- TX_DEPTH, 16: TX FIFO entries; power of two, 2..256.
- RX_DEPTH, 16: RX FIFO entries; power of two, 2..256.
- DIV_W, 16: baud divisor register width.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- Presetn  in  1  asynchronous, active-low reset.
- Paddr  in  32  byte address; only bits [4:0] are decoded, upper bits ignored.
- Psel  in  1  APB select.
- Penable  in  1  APB access phase.
- Pwrite  in  1  1 = write.
- Pwdata  in  32  write data.
- Prdata  out  32  read data; valid in the access phase.
- Pready  out  1  transfer complete.
- Pslverr  out  1  transfer error; qualified by Pready.
- IRQ  out  1  level interrupt, registered.
- TXD  out  1  serial out; idles high.
- RXD  in  1  serial in; asynchronous, double-flop synchronised.
- baud_o  out  1  one-clk pulse per 16x oversample tick.

## Operation
Register map (word offsets):
- 0x00 DATA. Write: push Pwdata[7:0] into the TX FIFO. Read: pop the RX FIFO; returns {24'b0, byte}.
- 0x04 STATUS, read-only:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
  - [4] overrun, sticky. [5] frame_err, sticky.
  - [6] tx_busy (shifter not IDLE).
- 0x08 CTRL, R/W, reset 0:
  - [0] tx_en, [1] rx_en.
  - [2] ie_tx_empty, [3] ie_rx_avail, [4] ie_err.
- 0x0C DIV, R/W, reset 1. DIV=0 stops ticks.
- 0x10 CLR, write-only: 1 in bit 4 clears overrun, 1 in bit 5 clears frame_err. Reads return 0.

Pslverr=1 cases (no state change in every case):
- Unmapped offset.
- Write to STATUS.
- Write to DATA while tx_full; byte dropped.
- Read of DATA while rx_empty; Prdata=0.

Baud generator:
- Down-counter reloads DIV-1 and pulses baud_o when it reaches 0.
- One tick every DIV clocks; bit period is 16 ticks.
- A DIV write reloads the counter immediately.

TX FSM (IDLE, START, DATA, STOP):
- IDLE → START when tx_en=1 and the FIFO is not empty; pops the FIFO on the same clk.
- Each state lasts 16 ticks. DATA shifts LSB first for 8 bits.
- STOP → START directly if another byte is pending, otherwise → IDLE.
- Clearing tx_en completes the current frame, then stays in IDLE.

RX FSM (IDLE, START, DATA, STOP):
- IDLE → START on a falling edge of synchronised RXD with rx_en=1.
- START: samples at tick 8. If RXD is high, the start is false and the FSM returns to IDLE.
- DATA samples each bit at its centre (every 16 ticks).
- STOP sample = 0: set frame_err and discard the byte.
- STOP sample = 1 with RX FIFO full: set overrun and drop the byte.
- STOP sample = 1 otherwise: push the byte.

IRQ, registered one clk after the condition:
- IRQ = (ie_tx_empty & tx_empty & !tx_busy) | (ie_rx_avail & !rx_empty) | (ie_err & (overrun | frame_err)).

Simultaneous events:
- APB pop and RX push in the same clk are both honoured; occupancy is unchanged.
- A sticky flag being set and cleared in the same clk: the set wins.

## Timing
- Zero wait states: Pready = Psel & Penable, combinational. Pslverr and Prdata are valid in the same cycle.
- The FIFO push/pop and register write take effect at the clk edge ending the access phase. STATUS reflects it on the next read.
- TX latency: the DATA write completes at edge E; with the FSM IDLE and tx_en=1, TXD falls at E+1.
- Frame length: 160 ticks = 160·DIV clks.
- RX: byte is visible in the FIFO 2 clks (synchroniser) after the stop-bit centre sample, plus 1 clk.
- Reset values:
  - Prdata=0, Pready=0, Pslverr=0, IRQ=0, TXD=1, baud_o=0.
  - FIFOs empty, flags 0, FSMs IDLE.
- Reset asserted mid-frame: TXD goes to 1 immediately (async). The partial RX byte is lost.
- FIFO pointers are (log2 DEPTH + 1) bits with an MSB wrap bit: full when the low bits are equal and the MSBs differ; empty when the pointers are equal.

## Test plan
- Reset, then read STATUS → 0x0A (tx_empty, rx_empty); DIV reads 1; TXD=1; IRQ=0.
- DIV=2, CTRL=0x3, write DATA=0xA5 → TXD: start bit 32 clks, then bits 1,0,1,0,0,1,0,1 at 32 clks each, then stop; frame 320 clks. baud_o period is 2 clks.
- TXD looped to RXD, CTRL=0xB, write 0x3C → IRQ rises after the frame; DATA read returns 0x3C; IRQ drops 1 clk later.
- tx_en=0, write TX_DEPTH+1 bytes → last write Pslverr=1; STATUS[0]=1. Read DATA while empty → Prdata=0, Pslverr=1. Access offset 0x14 → Pslverr=1.
- Inject RX_DEPTH+1 frames without reading → STATUS[4]=1, IRQ=1 with ie_err set. Inject a frame with stop=0 → STATUS[5]=1. CLR=0x30 → both flags clear.
- Assert Presetn low mid-TX frame → TXD=1 immediately; after release, STATUS=0x0A.

Source files
------------

// File: rtl/apb_uart_core.sv
//------------------------------------------------------------------------------
// apb_uart_core
//
// APB3 slave UART with 8N1 framing. It has a small register file, TX and RX
// FIFOs, a programmable 16x-oversampling baud generator, a maskable level
// interrupt and APB error signalling.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   Presetn   asynchronous active-low reset
//   Paddr     byte address, only [4:0] decoded
//   Psel      APB select
//   Penable   APB access phase
//   Pwrite    1 = write
//   Pwdata    write data
//   Prdata    read data, valid in the access phase
//   Pready    transfer complete (always zero wait states)
//   Pslverr   transfer error, qualified by Pready
//   IRQ       registered level interrupt
//   TXD       serial out, idles high
//   RXD       asynchronous serial in
//   baud_o    one-clk pulse per 16x oversample tick
//
// Register map (word offsets)
//   0x00 DATA   W: push TX FIFO   R: pop RX FIFO
//   0x04 STATUS R: {tx_busy, frame_err, overrun, rx_empty, rx_full,
//                   tx_empty, tx_full}
//   0x08 CTRL   R/W: {ie_err, ie_rx_avail, ie_tx_empty, rx_en, tx_en}
//   0x0C DIV    R/W: clocks per oversample tick, 0 stops the generator
//   0x10 CLR    W: bit 4 clears overrun, bit 5 clears frame_err
//------------------------------------------------------------------------------
module apb_uart_core #(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16,
   parameter int DIV_W    = 16
) (
   input  logic        clk,
   input  logic        Presetn,
   input  logic [31:0] Paddr,
   input  logic        Psel,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Pready,
   output logic        Pslverr,
   output logic        IRQ,
   output logic        TXD,
   input  logic        RXD,
   output logic        baud_o
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0]   TX_PTR_ONE = 1;
   localparam logic [RX_AW:0]   RX_PTR_ONE = 1;
   localparam logic [DIV_W-1:0] DIV_ONE    = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

   // Register file
   logic [4:0]       ctrl;
   logic             tx_en, rx_en, ie_tx_empty, ie_rx_avail, ie_err;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] baud_cnt;
   logic             tick;
   logic             overrun, frame_err;

   // FIFOs
   logic [7:0]     tx_mem [TX_DEPTH];
   logic [TX_AW:0] tx_wr, tx_rd;
   logic           tx_full, tx_empty, tx_push, tx_pop;
   logic [7:0]     tx_head;

   logic [7:0]     rx_mem [RX_DEPTH];
   logic [RX_AW:0] rx_wr, rx_rd;
   logic           rx_full, rx_empty, rx_push, rx_pop;
   logic [7:0]     rx_head;

   // APB decode
   logic       access;
   logic [4:0] offset;
   logic       sel_data, sel_stat, sel_ctrl, sel_div, sel_clr, mapped;
   logic       apb_err, wr_ok, rd_ok;
   logic       ctrl_wr, div_wr, clr_wr;
   logic       unused_bits;

   // Transmitter
   uart_state_t tx_state, tx_state_n;
   logic [3:0]  tx_ticks, tx_ticks_n;
   logic [2:0]  tx_bits, tx_bits_n;
   logic [7:0]  tx_sh, tx_sh_n;
   logic        txd_n, tx_bit_end, tx_busy;

   // Receiver
   uart_state_t rx_state, rx_state_n;
   logic [3:0]  rx_ticks, rx_ticks_n;
   logic [2:0]  rx_bits, rx_bits_n;
   logic [7:0]  rx_sh, rx_sh_n;
   logic        rxd_meta, rxd_sync, rxd_prev, rx_fall, rx_bit_end;
   logic        ovr_set, fe_set;

   assign tx_en       = ctrl[0];
   assign rx_en       = ctrl[1];
   assign ie_tx_empty = ctrl[2];
   assign ie_rx_avail = ctrl[3];
   assign ie_err      = ctrl[4];

   assign unused_bits = ^{Paddr[31:5], Pwdata[31:8]};

   // Pointers carry one extra wrap bit so full and empty can be told apart
   assign tx_full  = (tx_wr[TX_AW] != tx_rd[TX_AW]) &&
                     (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
   assign tx_empty = (tx_wr == tx_rd);
   assign tx_head  = tx_mem[tx_rd[TX_AW-1:0]];

   assign rx_full  = (rx_wr[RX_AW] != rx_rd[RX_AW]) &&
                     (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]);
   assign rx_empty = (rx_wr == rx_rd);
   assign rx_head  = rx_mem[rx_rd[RX_AW-1:0]];

   assign access   = Psel & Penable;
   assign offset   = Paddr[4:0];
   assign sel_data = (offset == 5'h00);
   assign sel_stat = (offset == 5'h04);
   assign sel_ctrl = (offset == 5'h08);
   assign sel_div  = (offset == 5'h0C);
   assign sel_clr  = (offset == 5'h10);
   assign mapped   = sel_data | sel_stat | sel_ctrl | sel_div | sel_clr;

   // An errored access must not change any state, so every side effect
   // below is qualified by the error-free strobes wr_ok / rd_ok
   always_comb begin
      apb_err = 1'b0;
      if (!mapped)
         apb_err = 1'b1;
      else if (Pwrite && sel_stat)
         apb_err = 1'b1;
      else if (Pwrite && sel_data && tx_full)
         apb_err = 1'b1;
      else if (!Pwrite && sel_data && rx_empty)
         apb_err = 1'b1;
   end

   assign Pready  = access;
   assign Pslverr = access & apb_err;
   assign wr_ok   = access & Pwrite & ~apb_err;
   assign rd_ok   = access & ~Pwrite & ~apb_err;
   assign tx_push = wr_ok & sel_data;
   assign rx_pop  = rd_ok & sel_data;
   assign ctrl_wr = wr_ok & sel_ctrl;
   assign div_wr  = wr_ok & sel_div;
   assign clr_wr  = wr_ok & sel_clr;

   assign tx_busy = (tx_state != ST_IDLE);

   // Read data is driven only during an error-free read so the bus sees 0
   // otherwise; CLR reads fall through to 0
   always_comb begin
      Prdata = '0;
      if (rd_ok) begin
         if (sel_data)
            Prdata = {24'h0, rx_head};
         else if (sel_stat)
            Prdata = {25'h0, tx_busy, frame_err, overrun,
                      rx_empty, rx_full, tx_empty, tx_full};
         else if (sel_ctrl)
            Prdata = {27'h0, ctrl};
         else if (sel_div)
            Prdata = 32'(div_reg);
      end
   end

   // Control/status registers and the registered interrupt; a sticky flag
   // set in the same clk as its clear stays set
   always_ff @(posedge clk or negedge Presetn) begin
      if (!Presetn) begin
         ctrl      <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         IRQ       <= 1'b0;
      end else begin
         if (ctrl_wr)
            ctrl <= Pwdata[4:0];
         if (ovr_set)
            overrun <= 1'b1;
         else if (clr_wr && Pwdata[4])
            overrun <= 1'b0;
         if (fe_set)
            frame_err <= 1'b1;
         else if (clr_wr && Pwdata[5])
            frame_err <= 1'b0;
         IRQ <= (ie_tx_empty & tx_empty & ~tx_busy) |
                (ie_rx_avail & ~rx_empty) |
                (ie_err & (overrun | frame_err));
      end
   end

   // Baud generator: down-counter that pulses on reaching zero; a DIV write
   // restarts the count so the new rate takes effect immediately
   always_ff @(posedge clk or negedge Presetn) begin
      if (!Presetn) begin
         div_reg  <= DIV_ONE;
         baud_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (div_wr) begin
            div_reg  <= Pwdata[DIV_W-1:0];
            baud_cnt <= Pwdata[DIV_W-1:0] - DIV_ONE;
         end else if (div_reg != '0) begin
            if (baud_cnt == '0) begin
               baud_cnt <= div_reg - DIV_ONE;
               tick     <= 1'b1;
            end else begin
               baud_cnt <= baud_cnt - DIV_ONE;
            end
         end
      end
   end

   assign baud_o = tick;

   // FIFO pointers; a push and a pop in the same clk both proceed
   always_ff @(posedge clk or negedge Presetn) begin
      if (!Presetn) begin
         tx_wr <= '0;
         tx_rd <= '0;
         rx_wr <= '0;
         rx_rd <= '0;
      end else begin
         if (tx_push)
            tx_wr <= tx_wr + TX_PTR_ONE;
         if (tx_pop)
            tx_rd <= tx_rd + TX_PTR_ONE;
         if (rx_push)
            rx_wr <= rx_wr + RX_PTR_ONE;
         if (rx_pop)
            rx_rd <= rx_rd + RX_PTR_ONE;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wr[TX_AW-1:0]] <= Pwdata[7:0];
      if (rx_push)
         rx_mem[rx_wr[RX_AW-1:0]] <= rx_sh_n;
   end

   // Transmitter state register; TXD is registered so the pad never glitches
   always_ff @(posedge clk or negedge Presetn) begin
      if (!Presetn) begin
         tx_state <= ST_IDLE;
         tx_ticks <= '0;
         tx_bits  <= '0;
         tx_sh    <= '0;
         TXD      <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_ticks <= tx_ticks_n;
         tx_bits  <= tx_bits_n;
         tx_sh    <= tx_sh_n;
         TXD      <= txd_n;
      end
   end

   assign tx_bit_end = tick && (tx_ticks == 4'd15);

   // Transmitter next state; back-to-back frames go STOP -> START so the
   // line never idles between queued bytes
   always_comb begin
      tx_state_n = tx_state;
      tx_ticks_n = tx_ticks;
      tx_bits_n  = tx_bits;
      tx_sh_n    = tx_sh;
      tx_pop     = 1'b0;
      txd_n      = 1'b1;
      if (tick && (tx_state != ST_IDLE))
         tx_ticks_n = tx_ticks + 4'd1;
      case (tx_state)
         ST_IDLE: begin
            if (tx_en && !tx_empty) begin
               tx_state_n = ST_START;
               tx_pop     = 1'b1;
               tx_sh_n    = tx_head;
               tx_ticks_n = '0;
               tx_bits_n  = '0;
            end
         end
         ST_START: begin
            if (tx_bit_end)
               tx_state_n = ST_DATA;
         end
         ST_DATA: begin
            if (tx_bit_end) begin
               if (tx_bits == 3'd7) begin
                  tx_state_n = ST_STOP;
               end else begin
                  tx_bits_n = tx_bits + 3'd1;
                  tx_sh_n   = {1'b0, tx_sh[7:1]};
               end
            end
         end
         ST_STOP: begin
            if (tx_bit_end) begin
               if (tx_en && !tx_empty) begin
                  tx_state_n = ST_START;
                  tx_pop     = 1'b1;
                  tx_sh_n    = tx_head;
                  tx_bits_n  = '0;
               end else begin
                  tx_state_n = ST_IDLE;
               end
            end
         end
         default: tx_state_n = ST_IDLE;
      endcase
      case (tx_state_n)
         ST_START: txd_n = 1'b0;
         ST_DATA:  txd_n = tx_sh_n[0];
         default:  txd_n = 1'b1;
      endcase
   end

   // RXD double-flop synchroniser plus one more stage for edge detection
   always_ff @(posedge clk or negedge Presetn) begin
      if (!Presetn) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= RXD;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   assign rx_fall = rxd_prev & ~rxd_sync;

   // Receiver state register
   always_ff @(posedge clk or negedge Presetn) begin
      if (!Presetn) begin
         rx_state <= ST_IDLE;
         rx_ticks <= '0;
         rx_bits  <= '0;
         rx_sh    <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_ticks <= rx_ticks_n;
         rx_bits  <= rx_bits_n;
         rx_sh    <= rx_sh_n;
      end
   end

   assign rx_bit_end = tick && (rx_ticks == 4'd15);

   // Receiver next state; the start bit is checked half a bit in, which
   // puts every later 16-tick sample at the centre of its bit
   always_comb begin
      rx_state_n = rx_state;
      rx_ticks_n = rx_ticks;
      rx_bits_n  = rx_bits;
      rx_sh_n    = rx_sh;
      rx_push    = 1'b0;
      ovr_set    = 1'b0;
      fe_set     = 1'b0;
      if (tick && (rx_state != ST_IDLE))
         rx_ticks_n = rx_ticks + 4'd1;
      case (rx_state)
         ST_IDLE: begin
            if (rx_en && rx_fall) begin
               rx_state_n = ST_START;
               rx_ticks_n = '0;
               rx_bits_n  = '0;
            end
         end
         ST_START: begin
            if (tick && (rx_ticks == 4'd7)) begin
               rx_ticks_n = '0;
               if (rxd_sync)
                  rx_state_n = ST_IDLE;
               else
                  rx_state_n = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_bit_end) begin
               rx_sh_n = {rxd_sync, rx_sh[7:1]};
               if (rx_bits == 3'd7)
                  rx_state_n = ST_STOP;
               else
                  rx_bits_n = rx_bits + 3'd1;
            end
         end
         ST_STOP: begin
            if (rx_bit_end) begin
               rx_state_n = ST_IDLE;
               if (!rxd_sync)
                  fe_set = 1'b1;
               else if (rx_full)
                  ovr_set = 1'b1;
               else
                  rx_push = 1'b1;
            end
         end
         default: rx_state_n = ST_IDLE;
      endcase
   end

endmodule
